// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the scan configuration chain.
// The optional parity check is enabled by defining SCAN_PARITY_EN.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    UPDATE  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Default build sizing; the top recomputes these from its own parameters.
  localparam int CHAIN_LEN_DEF = 1600;
  localparam int LANES_DEF     = 1;
  localparam int DEPTH         = CHAIN_LEN_DEF / LANES_DEF;
  localparam int CNT_W         = $clog2(DEPTH + 2);

  function automatic int depth_of(input int chain_len, input int lanes);
    return chain_len / lanes;
  endfunction

  // Counter must hold 0..DEPTH+1, where DEPTH+1 marks an overlong load.
  function automatic int cnt_w_of(input int depth);
    return $clog2(depth + 2);
  endfunction

  function automatic bit chain_len_ok(input int chain_len, input int lanes);
    return (lanes > 0) && (chain_len % lanes == 0);
  endfunction

endpackage

// File: rtl/scan_lane.sv
// One DEPTH-bit serial segment: shifts toward bit 0, parallel load has priority.
module scan_lane #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             load,
  input  logic             serial_in,
  input  logic [DEPTH-1:0] load_data,
  output logic             serial_out,
  output logic [DEPTH-1:0] bits
);

  logic [DEPTH-1:0] sr;
  logic [DEPTH-1:0] shifted;

  if (DEPTH == 1) begin : g_one
    assign shifted = serial_in;
  end else begin : g_many
    assign shifted = {serial_in, sr[DEPTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= shifted;
    end
  end

  assign serial_out = sr[0];
  assign bits       = sr;

endmodule

// File: rtl/scan_cfg_chain.sv
// Multi-lane serial config chain with shadow register, status capture and length check.
// Define SCAN_PARITY_EN to add parity_in and require even parity on update.
module scan_cfg_chain
  import scan_pkg::*;
#(
  parameter int                   CHAIN_LEN = 1600,
  parameter int                   LANES     = 1,
  parameter logic [CHAIN_LEN-1:0] CFG_RESET = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic [LANES-1:0]     shreg_in,
  output logic [LANES-1:0]     shreg_out,
  input  logic                 update_req,
  input  logic                 capture_req,
  input  logic [CHAIN_LEN-1:0] capture_data,
`ifdef SCAN_PARITY_EN
  input  logic                 parity_in,
`endif
  output logic [CHAIN_LEN-1:0] cfg_q,
  output logic                 cfg_valid,
  output logic                 update_done,
  output logic                 update_err,
  output logic                 busy
);

  localparam int LANE_DEPTH = depth_of(CHAIN_LEN, LANES);
  localparam int CNT_BITS   = cnt_w_of(LANE_DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(LANE_DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_SAT  = CNT_BITS'(LANE_DEPTH + 1);

  if (!chain_len_ok(CHAIN_LEN, LANES)) begin : g_bad_len
    $error("scan_cfg_chain: CHAIN_LEN must be a multiple of LANES");
  end

  state_t               state, state_nxt;
  logic [CNT_BITS-1:0]  shift_cnt;
  logic [CHAIN_LEN-1:0] sr;
  logic                 do_shift, do_capture, update_ok;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    scan_lane #(.DEPTH(LANE_DEPTH)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .shift      (do_shift),
      .load       (do_capture),
      .serial_in  (shreg_in[l]),
      .load_data  (capture_data[l*LANE_DEPTH +: LANE_DEPTH]),
      .serial_out (shreg_out[l]),
      .bits       (sr[l*LANE_DEPTH +: LANE_DEPTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Update beats capture beats shift; requests are only heard in IDLE/SHIFT.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, SHIFT: begin
        if (update_req)       state_nxt = UPDATE;
        else if (capture_req) state_nxt = CAPTURE;
        else if (shift_en)    state_nxt = SHIFT;
        else                  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == UPDATE) || (state == CAPTURE);
    do_shift   = !busy && !update_req && !capture_req && shift_en;
    do_capture = (state == CAPTURE);
`ifdef SCAN_PARITY_EN
    update_ok  = (state == UPDATE) && (shift_cnt == CNT_FULL) && ((^sr) == parity_in);
`else
    update_ok  = (state == UPDATE) && (shift_cnt == CNT_FULL);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt   <= '0;
      cfg_q       <= CFG_RESET;
      cfg_valid   <= 1'b0;
      update_done <= 1'b0;
      update_err  <= 1'b0;
    end else begin
      update_done <= update_ok;
      update_err  <= (state == UPDATE) && !update_ok;
      if (update_ok) begin
        cfg_q     <= sr;
        cfg_valid <= 1'b1;
      end
      if (busy) begin
        shift_cnt <= '0;
      end else if (do_shift && shift_cnt != CNT_SAT) begin
        shift_cnt <= shift_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_cfg_chain.sv
// Directed bench for scan_cfg_chain at CHAIN_LEN=16, LANES=2 (DEPTH=8).
// Define SCAN_PARITY_EN to also exercise the parity check.
module tb_scan_cfg_chain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        shift_en = 1'b0;
  logic [1:0]  shreg_in = '0;
  logic [1:0]  shreg_out;
  logic        update_req = 1'b0;
  logic        capture_req = 1'b0;
  logic [15:0] capture_data = '0;
  logic        parity_in = 1'b0;
  logic [15:0] cfg_q;
  logic        cfg_valid;
  logic        update_done;
  logic        update_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scan_cfg_chain #(
    .CHAIN_LEN (16),
    .LANES     (2),
    .CFG_RESET (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .shift_en     (shift_en),
    .shreg_in     (shreg_in),
    .shreg_out    (shreg_out),
    .update_req   (update_req),
    .capture_req  (capture_req),
    .capture_data (capture_data),
`ifdef SCAN_PARITY_EN
    .parity_in    (parity_in),
`endif
    .cfg_q        (cfg_q),
    .cfg_valid    (cfg_valid),
    .update_done  (update_done),
    .update_err   (update_err),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane 0 takes w0, lane 1 takes w1, bit 0 first.
  task automatic shift_bits(input logic [15:0] w0, input logic [15:0] w1, input int n);
    for (int i = 0; i < n; i++) begin
      shift_en = 1'b1;
      shreg_in = {w1[i], w0[i]};
      tick();
    end
    shift_en = 1'b0;
    shreg_in = '0;
  endtask

  task automatic do_update(input string tag, input logic exp_done);
    update_req = 1'b1;
    tick();
    update_req = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_early_pulse"}, {update_done, update_err}, 0);
    tick();
    check({tag, "_done"}, update_done, exp_done);
    check({tag, "_err"}, update_err, !exp_done);
    check({tag, "_idle"}, busy, 0);
    tick();
    check({tag, "_pulse_end"}, {update_done, update_err}, 0);
  endtask

  initial begin
    logic [15:0] cap;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_cfg_q", cfg_q, 16'h0000);
    check("rst_valid", cfg_valid, 0);
    check("rst_out", shreg_out, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_pulses", {update_done, update_err}, 0);

    // 1. Reset lands on the UPDATE cycle
    shift_bits(16'h00A5, 16'h003C, 8);
    update_req = 1'b1;
    tick();
    update_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t1_cfg_q", cfg_q, 16'h0000);
    check("t1_valid", cfg_valid, 0);
    check("t1_pulses", {update_done, update_err}, 0);
    check("t1_busy", busy, 0);
    tick();
    check("t1_pulses_late", {update_done, update_err}, 0);
    check("t1_out", shreg_out, 2'b00);

    // 2. Full-length load then update
    shift_bits(16'h00A5, 16'h003C, 8);
    check("t2_out", shreg_out, 2'b01);
    do_update("t2", 1'b1);
    check("t2_cfg_q", cfg_q, 16'h3CA5);
    check("t2_valid", cfg_valid, 1);

    // 3. Short and long loads are rejected
    shift_bits(16'h00FF, 16'h00FF, 7);
    do_update("t3_short", 1'b0);
    check("t3_short_cfg_q", cfg_q, 16'h3CA5);
    shift_bits(16'h01FF, 16'h01FF, 9);
    do_update("t3_long", 1'b0);
    check("t3_long_cfg_q", cfg_q, 16'h3CA5);
    check("t3_valid", cfg_valid, 1);

    // 4. Capture then serial readback, shifting new data in behind it
    cap = 16'hBEEF;
    capture_data = cap;
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    check("t4_busy", busy, 1);
    tick();
    capture_data = '0;
    check("t4_idle", busy, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_rd%0d", i), shreg_out, {cap[8+i], cap[i]});
      shift_en = 1'b1;
      shreg_in = {cap[0] ^ cap[0] ^ 1'b0, 1'b0};
      shreg_in = {logic'((16'h00C3 >> i) & 1), logic'((16'h005A >> i) & 1)};
      tick();
    end
    shift_en = 1'b0;
    shreg_in = '0;
    check("t4_out_after", shreg_out, 2'b10);
    check("t4_cfg_q", cfg_q, 16'h3CA5);

    // 5. Simultaneous update+capture with shift_en; shift_en held while busy
    capture_data = 16'hBEEF;
    update_req  = 1'b1;
    capture_req = 1'b1;
    shift_en    = 1'b1;
    shreg_in    = 2'b11;
    tick();
    update_req  = 1'b0;
    capture_req = 1'b0;
    check("t5_busy", busy, 1);
    check("t5_no_shift", shreg_out, 2'b10);
    tick();
    shift_en = 1'b0;
    shreg_in = '0;
    check("t5_done", update_done, 1);
    check("t5_err", update_err, 0);
    check("t5_cfg_q", cfg_q, 16'hC35A);
    check("t5_busy_ignored", shreg_out, 2'b10);
    tick();
    capture_data = '0;
    check("t5_no_capture", busy, 0);
    check("t5_pulse_end", update_done, 0);
    check("t5_chain_kept", shreg_out, 2'b10);

`ifdef SCAN_PARITY_EN
    // 6. Parity: chain 3CA5 has even parity
    shift_bits(16'h00A5, 16'h003C, 8);
    parity_in = 1'b1;
    do_update("t6_bad", 1'b0);
    check("t6_bad_cfg_q", cfg_q, 16'hC35A);
    shift_bits(16'h00A5, 16'h003C, 8);
    parity_in = 1'b0;
    do_update("t6_good", 1'b1);
    check("t6_good_cfg_q", cfg_q, 16'h3CA5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
